// File: rtl/lsu_dccm_banked_mem_pkg.sv
// Shared geometry defaults and width helpers for the banked DCCM data array.
package lsu_dccm_banked_mem_pkg;

  localparam int unsigned DEF_NUM_BANKS  = 8;
  localparam int unsigned DEF_BYTE_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 39;
  localparam int unsigned DEF_ADDR_BITS  = 16;
  localparam int unsigned DEF_WB_DEPTH   = 2;

  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned width_bits(input int unsigned byte_width);
    return $clog2(byte_width);
  endfunction

  function automatic int unsigned index_bits(input int unsigned addr_bits,
                                             input int unsigned num_banks,
                                             input int unsigned byte_width);
    return addr_bits - $clog2(num_banks) - $clog2(byte_width);
  endfunction

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lsu_dccm_wrbuf.sv
// DCCM write buffer: in-order FIFO with a head drain port and a
// youngest-match forwarding CAM for the two read ports.
module lsu_dccm_wrbuf
  import lsu_dccm_banked_mem_pkg::*;
#(
  parameter int unsigned BANK_BITS  = 3,
  parameter int unsigned INDEX_BITS = 11,
  parameter int unsigned DATA_WIDTH = 39,
  parameter int unsigned WB_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  enq_i,
  input  logic [BANK_BITS-1:0]  enq_bank_i,
  input  logic [INDEX_BITS-1:0] enq_idx_i,
  input  logic [DATA_WIDTH-1:0] enq_data_i,
  input  logic                  deq_i,
  output logic                  full_c,
  output logic                  empty_c,
  output logic [BANK_BITS-1:0]  head_bank_c,
  output logic [INDEX_BITS-1:0] head_idx_c,
  output logic [DATA_WIDTH-1:0] head_data_c,
  input  logic [BANK_BITS-1:0]  lo_bank_i,
  input  logic [INDEX_BITS-1:0] lo_idx_i,
  output logic                  lo_hit_c,
  output logic [DATA_WIDTH-1:0] lo_data_c,
  input  logic [BANK_BITS-1:0]  hi_bank_i,
  input  logic [INDEX_BITS-1:0] hi_idx_i,
  output logic                  hi_hit_c,
  output logic [DATA_WIDTH-1:0] hi_data_c
);

  localparam int unsigned PTR_W = ptr_bits(WB_DEPTH);
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [INDEX_BITS-1:0] index;
    logic [BANK_BITS-1:0]  bank;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t        ent_q [WB_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c      = (cnt_q == CNT_W'(WB_DEPTH));
  assign empty_c     = (cnt_q == '0);
  assign head_bank_c = ent_q[rd_ptr_q].bank;
  assign head_idx_c  = ent_q[rd_ptr_q].index;
  assign head_data_c = ent_q[rd_ptr_q].data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq_i, deq_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (deq_i) ent_q[rd_ptr_q].valid <= 1'b0;
      if (enq_i) ent_q[wr_ptr_q] <= '{valid: 1'b1, index: enq_idx_i,
                                      bank: enq_bank_i, data: enq_data_i};
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lo_hit_c  = 1'b0;
    lo_data_c = '0;
    hi_hit_c  = 1'b0;
    hi_data_c = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] slot;
      sum  = {1'b0, rd_ptr_q} + (PTR_W + 1)'(k);
      slot = (sum >= (PTR_W + 1)'(WB_DEPTH)) ? PTR_W'(sum - (PTR_W + 1)'(WB_DEPTH))
                                             : PTR_W'(sum);
      if (ent_q[slot].valid && ent_q[slot].bank == lo_bank_i &&
          ent_q[slot].index == lo_idx_i) begin
        lo_hit_c  = 1'b1;
        lo_data_c = ent_q[slot].data;
      end
      if (ent_q[slot].valid && ent_q[slot].bank == hi_bank_i &&
          ent_q[slot].index == hi_idx_i) begin
        hi_hit_c  = 1'b1;
        hi_data_c = ent_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/lsu_dccm_banked_mem.sv
// Banked DCCM data array: read-priority banks, write buffer for conflicting
// writes, buffer forwarding into the read data, and freeze-held outputs.
module lsu_dccm_banked_mem
  import lsu_dccm_banked_mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned WB_DEPTH   = DEF_WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  lsu_freeze_dc3,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  input  logic [ADDR_BITS-1:0]  rd_addr_lo,
  input  logic [ADDR_BITS-1:0]  rd_addr_hi,
  output logic [DATA_WIDTH-1:0] rd_data_lo,
  output logic [DATA_WIDTH-1:0] rd_data_hi,
  output logic                  rd_data_valid,
  output logic                  wrbuf_empty
);

  localparam int unsigned BANK_BITS  = bank_bits(NUM_BANKS);
  localparam int unsigned WIDTH_BITS = width_bits(BYTE_WIDTH);
  localparam int unsigned INDEX_BITS = index_bits(ADDR_BITS, NUM_BANKS, BYTE_WIDTH);
  localparam int unsigned DEPTH      = 1 << INDEX_BITS;
  localparam int unsigned IDX_LSB    = WIDTH_BITS + BANK_BITS;

  logic [BANK_BITS-1:0]  rd_bank_lo, rd_bank_hi, wr_bank;
  logic [INDEX_BITS-1:0] rd_idx_lo, rd_idx_hi, wr_idx;
  logic                  unused_byte_bits;

  assign rd_bank_lo = rd_addr_lo[WIDTH_BITS +: BANK_BITS];
  assign rd_bank_hi = rd_addr_hi[WIDTH_BITS +: BANK_BITS];
  assign wr_bank    = wr_addr[WIDTH_BITS +: BANK_BITS];
  assign rd_idx_lo  = rd_addr_lo[ADDR_BITS-1:IDX_LSB];
  assign rd_idx_hi  = rd_addr_hi[ADDR_BITS-1:IDX_LSB];
  assign wr_idx     = wr_addr[ADDR_BITS-1:IDX_LSB];
  assign unused_byte_bits = ^{wr_addr[WIDTH_BITS-1:0], rd_addr_lo[WIDTH_BITS-1:0],
                              rd_addr_hi[WIDTH_BITS-1:0]};

  logic                 rd_fire, rd_split;
  logic [NUM_BANKS-1:0] bank_rd;

  assign rd_fire  = rd_valid & ~lsu_freeze_dc3;
  assign rd_split = (rd_bank_hi != rd_bank_lo);

  always_comb begin
    bank_rd = '0;
    if (rd_fire) begin
      bank_rd[rd_bank_lo] = 1'b1;
      if (rd_split) bank_rd[rd_bank_hi] = 1'b1;
    end
  end

  logic                  wb_full, wb_empty, wr_acc, wr_direct, wb_enq, wb_deq;
  logic [BANK_BITS-1:0]  head_bank;
  logic [INDEX_BITS-1:0] head_idx;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fwd_lo_hit, fwd_hi_hit;
  logic [DATA_WIDTH-1:0] fwd_lo_data, fwd_hi_data;

  assign wr_ready    = ~wb_full;
  assign wrbuf_empty = wb_empty;
  assign wr_acc      = wr_valid & ~wb_full;
  assign wr_direct   = wr_acc & wb_empty & ~lsu_freeze_dc3 & ~bank_rd[wr_bank];
  assign wb_enq      = wr_acc & ~wr_direct;
  assign wb_deq      = ~wb_empty & ~lsu_freeze_dc3 & ~bank_rd[head_bank];

  lsu_dccm_wrbuf #(
    .BANK_BITS  (BANK_BITS),
    .INDEX_BITS (INDEX_BITS),
    .DATA_WIDTH (DATA_WIDTH),
    .WB_DEPTH   (WB_DEPTH)
  ) u_wrbuf (
    .clk         (clk),
    .rst_l       (rst_l),
    .enq_i       (wb_enq),
    .enq_bank_i  (wr_bank),
    .enq_idx_i   (wr_idx),
    .enq_data_i  (wr_data),
    .deq_i       (wb_deq),
    .full_c      (wb_full),
    .empty_c     (wb_empty),
    .head_bank_c (head_bank),
    .head_idx_c  (head_idx),
    .head_data_c (head_data),
    .lo_bank_i   (rd_bank_lo),
    .lo_idx_i    (rd_idx_lo),
    .lo_hit_c    (fwd_lo_hit),
    .lo_data_c   (fwd_lo_data),
    .hi_bank_i   (rd_bank_hi),
    .hi_idx_i    (rd_idx_hi),
    .hi_hit_c    (fwd_hi_hit),
    .hi_data_c   (fwd_hi_data)
  );

  // Single bank write port: a direct write needs an empty buffer, so it never
  // collides with a drain.
  logic                  bw_en;
  logic [BANK_BITS-1:0]  bw_bank;
  logic [INDEX_BITS-1:0] bw_idx;
  logic [DATA_WIDTH-1:0] bw_data;

  assign bw_en   = wr_direct | wb_deq;
  assign bw_bank = wb_deq ? head_bank : wr_bank;
  assign bw_idx  = wb_deq ? head_idx  : wr_idx;
  assign bw_data = wb_deq ? head_data : wr_data;

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [INDEX_BITS-1:0] raddr;

    assign raddr         = (rd_bank_lo == BANK_BITS'(b)) ? rd_idx_lo : rd_idx_hi;
    assign bank_rdata[b] = mem_q[raddr];

    always_ff @(posedge clk) begin
      if (bw_en && (bw_bank == BANK_BITS'(b))) mem_q[bw_idx] <= bw_data;
    end
  end

  logic [DATA_WIDTH-1:0] rd_lo_d, rd_lo_q, rd_hi_d, rd_hi_q;
  logic                  rd_vld_q;

  always_comb begin
    rd_lo_d = fwd_lo_hit ? fwd_lo_data : bank_rdata[rd_bank_lo];
    rd_hi_d = rd_lo_d;
    if (rd_split) rd_hi_d = fwd_hi_hit ? fwd_hi_data : bank_rdata[rd_bank_hi];
  end

  // Data only loads on a live read; valid follows rd_valid unless frozen.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (rd_fire) begin
        rd_lo_q <= rd_lo_d;
        rd_hi_q <= rd_hi_d;
      end
      if (!lsu_freeze_dc3) rd_vld_q <= rd_valid;
    end
  end

  assign rd_data_lo    = rd_lo_q;
  assign rd_data_hi    = rd_hi_q;
  assign rd_data_valid = rd_vld_q;

endmodule

// File: tb/tb_lsu_dccm_banked_mem.sv
// Self-checking bench for lsu_dccm_banked_mem: directed scenarios plus a
// randomized run against an architectural word-memory model.
module tb_lsu_dccm_banked_mem;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 39;
  localparam int unsigned NB  = 8;
  localparam int unsigned WBD = 2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          lsu_freeze_dc3 = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr_lo = '0;
  logic [AW-1:0] rd_addr_hi = '0;
  logic [DW-1:0] rd_data_lo, rd_data_hi;
  logic          rd_data_valid;
  logic          wrbuf_empty;

  always #5 clk = ~clk;

  lsu_dccm_banked_mem #(
    .NUM_BANKS(NB), .BYTE_WIDTH(4), .DATA_WIDTH(DW), .ADDR_BITS(AW), .WB_DEPTH(WBD)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .lsu_freeze_dc3 (lsu_freeze_dc3),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_addr_lo     (rd_addr_lo),
    .rd_addr_hi     (rd_addr_hi),
    .rd_data_lo     (rd_data_lo),
    .rd_data_hi     (rd_data_hi),
    .rd_data_valid  (rd_data_valid),
    .wrbuf_empty    (wrbuf_empty)
  );

  int total = 0;
  int bad   = 0;

  // Architectural view: a write is part of memory once accepted.
  logic [DW-1:0] mdl [int];
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_lo = '0;
  logic [DW-1:0] exp_hi = '0;
  bit            exp_known = 1'b0;
  bit            last_acc = 1'b0;

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a >> 2);
  endfunction

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'((a >> 2) & 16'h7);
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int idx, input int bank);
    int off;
    off = int'($urandom_range(0, 3));
    return AW'((idx << 5) | (bank << 2) | off);
  endfunction

  // Advance one clock; expectations are formed from state before this cycle's write.
  task automatic tick();
    bit fire;
    fire     = rd_valid && !lsu_freeze_dc3;
    last_acc = wr_valid && wr_ready;
    if (fire) begin
      exp_valid = 1'b1;
      exp_known = mdl.exists(word_of(rd_addr_lo)) && mdl.exists(word_of(rd_addr_hi));
      exp_lo    = mdl.exists(word_of(rd_addr_lo)) ? mdl[word_of(rd_addr_lo)] : '0;
      if (bank_of(rd_addr_hi) == bank_of(rd_addr_lo)) exp_hi = exp_lo;
      else exp_hi = mdl.exists(word_of(rd_addr_hi)) ? mdl[word_of(rd_addr_hi)] : '0;
    end else if (!lsu_freeze_dc3) begin
      exp_valid = 1'b0;
    end
    if (last_acc) mdl[word_of(wr_addr)] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    lsu_freeze_dc3 = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (rd_data_lo !== '0) begin bad++; $display("FAIL reset_lo: got %h want 0", rd_data_lo); end
    total++; if (rd_data_hi !== '0) begin bad++; $display("FAIL reset_hi: got %h want 0", rd_data_hi); end
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rd_data_valid); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    total++; if (wrbuf_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", wrbuf_empty); end
    rst_l = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_basic();
    do_write(16'h0100, DW'(39'hA5));
    rd_valid = 1'b1; rd_addr_lo = 16'h0100; rd_addr_hi = 16'h0100;
    tick();
    total++; if (rd_data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rd_data_valid); end
    total++; if (rd_data_lo !== DW'(39'hA5)) begin bad++; $display("FAIL basic_lo: got %h want a5", rd_data_lo); end
    total++; if (rd_data_hi !== DW'(39'hA5)) begin bad++; $display("FAIL basic_hi: got %h want a5", rd_data_hi); end
    idle();
    tick();
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", rd_data_valid); end
    total++; if (rd_data_lo !== DW'(39'hA5)) begin bad++; $display("FAIL basic_hold: got %h want a5", rd_data_lo); end
  endtask

  task automatic test_conflict();
    logic [AW-1:0] a, b;
    a = mk_addr(1, 2);
    b = mk_addr(3, 2);
    do_write(a, DW'(39'h33));
    rd_valid = 1'b1; rd_addr_lo = a; rd_addr_hi = a;
    wr_valid = 1'b1; wr_addr = b; wr_data = DW'(39'h77);
    tick();
    total++; if (wrbuf_empty !== 1'b0) begin bad++; $display("FAIL conflict_buffered: got %b want 0", wrbuf_empty); end
    total++; if (rd_data_lo !== DW'(39'h33)) begin bad++; $display("FAIL conflict_old_read: got %h want 33", rd_data_lo); end
    idle();
    tick();
    total++; if (wrbuf_empty !== 1'b1) begin bad++; $display("FAIL conflict_drained: got %b want 1", wrbuf_empty); end
    tick();
    rd_valid = 1'b1; rd_addr_lo = b; rd_addr_hi = b;
    tick();
    total++; if (rd_data_lo !== DW'(39'h77)) begin bad++; $display("FAIL conflict_new_read: got %h want 77", rd_data_lo); end
  endtask

  task automatic test_fill();
    logic [AW-1:0] x, y;
    x = mk_addr(4, 3);
    y = mk_addr(4, 4);
    do_write(x, DW'(39'h40));
    do_write(y, DW'(39'h44));
    rd_valid = 1'b1; rd_addr_lo = mk_addr(6, 3); rd_addr_hi = mk_addr(6, 4);
    wr_valid = 1'b1; wr_addr = x; wr_data = DW'(39'h1);
    tick();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_one_ready: got %b want 1", wr_ready); end
    wr_data = DW'(39'h2);
    tick();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %b want 0", wr_ready); end
    wr_addr = y; wr_data = DW'(39'hBAD);
    tick();
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full: got %b want 0", wr_ready); end
    rd_valid = 1'b0;
    tick();
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_drain_ready: got %b want 1", wr_ready); end
    total++; if (wrbuf_empty !== 1'b0) begin bad++; $display("FAIL fill_one_left: got %b want 0", wrbuf_empty); end
    idle();
    tick();
    total++; if (wrbuf_empty !== 1'b1) begin bad++; $display("FAIL fill_empty: got %b want 1", wrbuf_empty); end
    rd_valid = 1'b1; rd_addr_lo = x; rd_addr_hi = y;
    tick();
    total++; if (rd_data_lo !== DW'(39'h2)) begin bad++; $display("FAIL fill_order: got %h want 2", rd_data_lo); end
    total++; if (rd_data_hi !== DW'(39'h44)) begin bad++; $display("FAIL fill_refused: got %h want 44", rd_data_hi); end
    idle();
    tick();
  endtask

  task automatic test_forward();
    logic [AW-1:0] p, z;
    p = mk_addr(1, 5);
    z = mk_addr(2, 5);
    idle();
    rd_valid = 1'b1; rd_addr_lo = p; rd_addr_hi = p;
    wr_valid = 1'b1; wr_addr = z; wr_data = DW'(39'h11);
    tick();
    wr_data = DW'(39'h22);
    tick();
    wr_valid = 1'b0; rd_addr_lo = z; rd_addr_hi = z;
    tick();
    total++; if (rd_data_lo !== DW'(39'h22)) begin bad++; $display("FAIL fwd_lo: got %h want 22", rd_data_lo); end
    total++; if (rd_data_hi !== DW'(39'h22)) begin bad++; $display("FAIL fwd_hi: got %h want 22", rd_data_hi); end
    total++; if (wrbuf_empty !== 1'b0) begin bad++; $display("FAIL fwd_pending: got %b want 0", wrbuf_empty); end
    idle();
    repeat (2) tick();
    rd_valid = 1'b1;
    tick();
    total++; if (rd_data_lo !== DW'(39'h22)) begin bad++; $display("FAIL fwd_array: got %h want 22", rd_data_lo); end
    idle();
    tick();
  endtask

  task automatic test_misaligned();
    logic [AW-1:0] l, h, s1, s2;
    l  = mk_addr(9, 7);
    h  = mk_addr(10, 0);
    s1 = mk_addr(9, 6);
    s2 = mk_addr(10, 6);
    do_write(l, DW'(39'h7007));
    do_write(h, DW'(39'h0A00));
    do_write(s1, DW'(39'h6609));
    do_write(s2, DW'(39'h660A));
    rd_valid = 1'b1; rd_addr_lo = l; rd_addr_hi = h;
    tick();
    total++; if (rd_data_lo !== DW'(39'h7007)) begin bad++; $display("FAIL mis_lo: got %h want 7007", rd_data_lo); end
    total++; if (rd_data_hi !== DW'(39'h0A00)) begin bad++; $display("FAIL mis_hi: got %h want a00", rd_data_hi); end
    rd_addr_lo = s1; rd_addr_hi = s2;
    tick();
    total++; if (rd_data_lo !== DW'(39'h6609)) begin bad++; $display("FAIL same_bank_lo: got %h want 6609", rd_data_lo); end
    total++; if (rd_data_hi !== DW'(39'h6609)) begin bad++; $display("FAIL same_bank_hi: got %h want 6609", rd_data_hi); end
    idle();
    tick();
  endtask

  task automatic test_freeze_reset();
    logic [AW-1:0] r, w;
    r = mk_addr(12, 1);
    w = mk_addr(13, 1);
    do_write(r, DW'(39'h1234));
    rd_valid = 1'b1; rd_addr_lo = r; rd_addr_hi = r;
    wr_valid = 1'b1; wr_addr = w; wr_data = DW'(39'h5678);
    tick();
    total++; if (rd_data_lo !== DW'(39'h1234)) begin bad++; $display("FAIL frz_pre_lo: got %h want 1234", rd_data_lo); end
    lsu_freeze_dc3 = 1'b1;
    rd_addr_lo = w; rd_addr_hi = w;
    wr_addr = mk_addr(14, 1); wr_data = DW'(39'h9);
    for (int c = 0; c < 3; c++) begin
      tick();
      wr_valid = 1'b0;
      total++; if (rd_data_valid !== 1'b1) begin bad++; $display("FAIL frz_valid c%0d: got %b want 1", c, rd_data_valid); end
      total++; if (rd_data_lo !== DW'(39'h1234)) begin bad++; $display("FAIL frz_lo c%0d: got %h want 1234", c, rd_data_lo); end
      total++; if (rd_data_hi !== DW'(39'h1234)) begin bad++; $display("FAIL frz_hi c%0d: got %h want 1234", c, rd_data_hi); end
      total++; if (wrbuf_empty !== 1'b0) begin bad++; $display("FAIL frz_nodrain c%0d: got %b want 0", c, wrbuf_empty); end
    end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL frz_enq_full: got %b want 0", wr_ready); end
    rst_l = 1'b0;
    #2;
    total++; if (rd_data_lo !== '0) begin bad++; $display("FAIL rst_mid_lo: got %h want 0", rd_data_lo); end
    total++; if (rd_data_hi !== '0) begin bad++; $display("FAIL rst_mid_hi: got %h want 0", rd_data_hi); end
    total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", rd_data_valid); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", wr_ready); end
    total++; if (wrbuf_empty !== 1'b1) begin bad++; $display("FAIL rst_mid_empty: got %b want 1", wrbuf_empty); end
    idle();
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    mdl.delete();
    exp_valid = 1'b0; exp_lo = '0; exp_hi = '0; exp_known = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int idx_set [4] = '{0, 1, 2, 2047};
    int guard;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < int'(NB); b++) begin
        idle();
        wr_valid = 1'b1; wr_addr = mk_addr(idx_set[i], b); wr_data = DW'({$urandom, $urandom});
        guard = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 10) begin tick(); guard++; end
        total++; if (!last_acc) begin bad++; $display("FAIL rand_preload: write to %h never accepted", wr_addr); end
      end
    end
    idle();
    tick();
    for (int n = 0; n < 3000; n++) begin
      int bl;
      lsu_freeze_dc3 = ($urandom_range(0, 7) == 0);
      rd_valid = ($urandom_range(0, 3) != 0);
      bl = int'($urandom_range(0, NB - 1));
      rd_addr_lo = mk_addr(idx_set[$urandom_range(0, 3)], bl);
      if ($urandom_range(0, 1) == 0) rd_addr_hi = mk_addr(idx_set[$urandom_range(0, 3)], bl);
      else rd_addr_hi = mk_addr(idx_set[$urandom_range(0, 3)], (bl + int'($urandom_range(1, NB - 1))) % int'(NB));
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr = mk_addr(idx_set[$urandom_range(0, 3)], int'($urandom_range(0, NB - 1)));
      wr_data = DW'({$urandom, $urandom});
      tick();
      total++; if (rd_data_valid !== exp_valid) begin bad++; $display("FAIL rand_valid n%0d: got %b want %b", n, rd_data_valid, exp_valid); end
      if (exp_known) begin
        total++; if (rd_data_lo !== exp_lo) begin bad++; $display("FAIL rand_lo n%0d: got %h want %h", n, rd_data_lo, exp_lo); end
        total++; if (rd_data_hi !== exp_hi) begin bad++; $display("FAIL rand_hi n%0d: got %h want %h", n, rd_data_hi, exp_hi); end
      end
    end
    idle();
    guard = 0;
    while (wrbuf_empty !== 1'b1 && guard < 20) begin tick(); guard++; end
    total++; if (wrbuf_empty !== 1'b1) begin bad++; $display("FAIL rand_drain: buffer not empty after %0d idle cycles", guard); end
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < int'(NB); b++) begin
        a = mk_addr(idx_set[i], b);
        rd_valid = 1'b1; rd_addr_lo = a; rd_addr_hi = a;
        tick();
        total++; if (rd_data_lo !== exp_lo) begin bad++; $display("FAIL rand_array %h: got %h want %h", a, rd_data_lo, exp_lo); end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_fill();
    test_forward();
    test_misaligned();
    test_freeze_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
